uc_eng_scheduler: RTL and testbench

// Sequences unit-clause (UC) traffic between NUM_ENGINE propagation engines and uc_arbiter for one round.

---
 rtl/uc_eng_scheduler.sv | 208 ++++++++++++++++++++
 tb/tb_uc_eng_scheduler.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_eng_scheduler.sv
// Unit-clause traffic sequencer for one solver round.
// Collects engine UCs into uc_arbiter and broadcasts the arbiter queue back to every engine.
module uc_eng_scheduler #(
  parameter int NUM_ENGINE = 4,
  parameter int LIT_W      = 10,
  parameter int MAX_UC     = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NUM_ENGINE-1:0]       eng_uc_valid,
  input  logic [NUM_ENGINE*LIT_W-1:0] eng_uc_lit,
  output logic [NUM_ENGINE-1:0]       eng_uc_pop,
  input  logic [NUM_ENGINE-1:0]       eng_idle,
  output logic                        sch2uca_valid,
  output logic [LIT_W-1:0]            sch2uca_lit,
  input  logic                        uca_ready,
  input  logic                        uca2sch_valid,
  input  logic [LIT_W-1:0]            uca2sch_lit,
  output logic                        sch2uca_rd,
  input  logic [NUM_ENGINE-1:0]       eng_rcv_full,
  output logic [NUM_ENGINE-1:0]       eng_rcv_push,
  output logic [LIT_W-1:0]            eng_rcv_lit,
  input  logic                        uca_conflict,
  output logic                        round_done,
  output logic                        conflict_out,
  output logic                        overflow,
  output logic [$clog2(MAX_UC+1)-1:0] uc_count
);

  localparam int CNT_W = $clog2(MAX_UC + 1);
  localparam int IDX_W = (NUM_ENGINE > 1) ? $clog2(NUM_ENGINE) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACTIVE = 3'd1,
    S_DRAIN  = 3'd2,
    S_DONE   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t                state;
  logic [IDX_W-1:0]      rr;
  logic [NUM_ENGINE-1:0] bc_pend;
  logic [LIT_W-1:0]      bc_lit;
  logic                  grant_hit;
  logic                  hit_k;
  logic [IDX_W-1:0]      grant_idx;
  logic [LIT_W-1:0]      grant_lit;
  logic [CNT_W:0]        committed;
  logic                  load;
  logic                  xfer;
  logic                  bc_active;

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int offs);
    return IDX_W'((int'(base) + offs) % NUM_ENGINE);
  endfunction

  // Round-robin search starting one past the last granted engine
  always_comb begin
    grant_hit = 1'b0;
    hit_k     = 1'b0;
    grant_idx = rr;
    for (int k = 1; k <= NUM_ENGINE; k++) begin
      hit_k     = eng_uc_valid[rr_idx(rr, k)] & ~grant_hit;
      grant_idx = hit_k ? rr_idx(rr, k) : grant_idx;
      grant_hit = grant_hit | hit_k;
    end
  end

  // Head literal of the granted engine
  always_comb begin
    grant_lit = {LIT_W{1'b0}};
    for (int k = 0; k < NUM_ENGINE; k++) begin
      grant_lit = (grant_idx == IDX_W'(k)) ? eng_uc_lit[k*LIT_W +: LIT_W] : grant_lit;
    end
  end

  // committed counts the literal sitting in the slot, so the budget is never overshot by the pipeline
  assign xfer      = sch2uca_valid & uca_ready;
  assign committed = {1'b0, uc_count} + {{CNT_W{1'b0}}, sch2uca_valid};
  assign load      = (state == S_ACTIVE) && !uca_conflict && !overflow &&
                     (!sch2uca_valid || uca_ready) && grant_hit &&
                     (committed < (CNT_W+1)'(MAX_UC));

  // One-hot pop of the engine whose literal is loaded this cycle
  always_comb begin
    eng_uc_pop = {NUM_ENGINE{1'b0}};
    if (load) begin
      eng_uc_pop[grant_idx] = 1'b1;
    end else begin
      eng_uc_pop = {NUM_ENGINE{1'b0}};
    end
  end

  assign bc_active    = (state == S_ACTIVE) || (state == S_DRAIN);
  assign eng_rcv_push = bc_active ? (bc_pend & ~eng_rcv_full) : {NUM_ENGINE{1'b0}};
  assign sch2uca_rd   = bc_active && uca2sch_valid && ((bc_pend & eng_rcv_full) == {NUM_ENGINE{1'b0}});
  assign eng_rcv_lit  = bc_lit;

  // Round FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_IDLE;
      round_done   <= 1'b0;
      conflict_out <= 1'b0;
    end else begin
      round_done <= 1'b0;
      case (state)
        S_IDLE: begin
          state <= start ? S_ACTIVE : S_IDLE;
        end
        S_ACTIVE: begin
          if (uca_conflict) begin
            state        <= S_HALT;
            conflict_out <= 1'b1;
          end else if ((&eng_idle) && (eng_uc_valid == {NUM_ENGINE{1'b0}}) && !sch2uca_valid) begin
            state <= S_DRAIN;
          end else begin
            state <= S_ACTIVE;
          end
        end
        S_DRAIN: begin
          if (uca_conflict) begin
            state        <= S_HALT;
            conflict_out <= 1'b1;
          end else if (!uca2sch_valid && (bc_pend == {NUM_ENGINE{1'b0}})) begin
            state      <= S_DONE;
            round_done <= 1'b1;
          end else begin
            state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (uca_conflict) begin
            state        <= S_HALT;
            conflict_out <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_HALT: begin
          if (start) begin
            state        <= S_IDLE;
            conflict_out <= 1'b0;
          end else begin
            state <= S_HALT;
          end
        end
        default: begin
          state        <= S_IDLE;
          conflict_out <= 1'b0;
        end
      endcase
    end
  end

  // Collect path: output slot, round-robin pointer, literal budget
  always_ff @(posedge clk) begin
    if (!rst) begin
      sch2uca_valid <= 1'b0;
      sch2uca_lit   <= {LIT_W{1'b0}};
      rr            <= {IDX_W{1'b0}};
      uc_count      <= {CNT_W{1'b0}};
      overflow      <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      sch2uca_valid <= 1'b0;
      uc_count      <= {CNT_W{1'b0}};
      overflow      <= 1'b0;
    end else begin
      if ((state == S_ACTIVE) && xfer && (uc_count != CNT_W'(MAX_UC))) begin
        uc_count <= uc_count + CNT_W'(1);
      end else begin
        uc_count <= uc_count;
      end
      if ((state == S_ACTIVE) && (committed >= (CNT_W+1)'(MAX_UC)) && (|eng_uc_valid)) begin
        overflow <= 1'b1;
      end else begin
        overflow <= overflow;
      end
      if (load) begin
        sch2uca_valid <= 1'b1;
        sch2uca_lit   <= grant_lit;
        rr            <= grant_idx;
      end else if (xfer || (state != S_ACTIVE) || uca_conflict) begin
        sch2uca_valid <= 1'b0;
      end else begin
        sch2uca_valid <= sch2uca_valid;
      end
    end
  end

  // Broadcast path: each engine takes the current literal once, the next is read when none stays blocked
  always_ff @(posedge clk) begin
    if (!rst) begin
      bc_pend <= {NUM_ENGINE{1'b0}};
      bc_lit  <= {LIT_W{1'b0}};
    end else if (state == S_HALT) begin
      bc_pend <= {NUM_ENGINE{1'b0}};
    end else if (sch2uca_rd) begin
      bc_lit  <= uca2sch_lit;
      bc_pend <= {NUM_ENGINE{1'b1}};
    end else begin
      bc_pend <= bc_pend & ~eng_rcv_push;
    end
  end

endmodule

// File: tb/tb_uc_eng_scheduler.sv
// Scoreboard bench for uc_eng_scheduler: engine FIFO and arbiter queue models drive the
// design, expected literals are queued at stimulus time and compared when the design emits them.
module tb_uc_eng_scheduler;
  localparam int NE = 4;
  localparam int LW = 10;
  localparam int MU = 4;
  localparam int CW = $clog2(MU + 1);
  localparam logic [NE-1:0] RR_POP   [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
  localparam logic [NE-1:0] BC_FULL  [6] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
  localparam logic [NE-1:0] BC_PUSH  [6] = '{4'b0000, 4'b1011, 4'b0000, 4'b0100, 4'b1111, 4'b0000};
  localparam logic          BC_RD    [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  logic             clk = 1'b0;
  logic             rst, start, uca_ready, uca2sch_valid, uca_conflict;
  logic [NE-1:0]    eng_uc_valid, eng_idle, eng_rcv_full;
  logic [NE*LW-1:0] eng_uc_lit;
  logic [LW-1:0]    uca2sch_lit;
  logic [NE-1:0]    eng_uc_pop, eng_rcv_push;
  logic             sch2uca_valid, sch2uca_rd, round_done, conflict_out, overflow;
  logic [LW-1:0]    sch2uca_lit, eng_rcv_lit;
  logic [CW-1:0]    uc_count;

  int checks = 0;
  int errors = 0;
  logic [LW-1:0] col_q[$];
  logic [LW-1:0] arb_q[$];
  logic [LW-1:0] bc_exp[$];
  int            bc_idx[NE];
  logic [LW-1:0] eng_lit[NE];
  int            eng_cnt[NE];
  logic [NE-1:0] pop_s, push_s;
  logic          rd_s, xfer_s;
  logic [LW-1:0] xlit_s, rcv_lit_s, exp_lit, tmp_lit;

  uc_eng_scheduler #(.NUM_ENGINE(NE), .LIT_W(LW), .MAX_UC(MU)) dut (
    .clk(clk), .rst(rst), .start(start),
    .eng_uc_valid(eng_uc_valid), .eng_uc_lit(eng_uc_lit), .eng_uc_pop(eng_uc_pop),
    .eng_idle(eng_idle),
    .sch2uca_valid(sch2uca_valid), .sch2uca_lit(sch2uca_lit), .uca_ready(uca_ready),
    .uca2sch_valid(uca2sch_valid), .uca2sch_lit(uca2sch_lit), .sch2uca_rd(sch2uca_rd),
    .eng_rcv_full(eng_rcv_full), .eng_rcv_push(eng_rcv_push), .eng_rcv_lit(eng_rcv_lit),
    .uca_conflict(uca_conflict), .round_done(round_done), .conflict_out(conflict_out),
    .overflow(overflow), .uc_count(uc_count)
  );

  always #5 clk = ~clk;

  // One cycle of environment: drive models, sample combinational outputs, clock, retire pops
  task automatic env_step();
    for (int i = 0; i < NE; i++) begin
      eng_uc_lit[i*LW +: LW] = eng_lit[i];
      eng_uc_valid[i]        = (eng_cnt[i] > 0);
    end
    uca2sch_valid = (arb_q.size() != 0);
    uca2sch_lit   = (arb_q.size() != 0) ? arb_q[0] : 10'h000;
    #1;
    pop_s     = eng_uc_pop;
    rd_s      = sch2uca_rd;
    push_s    = eng_rcv_push;
    rcv_lit_s = eng_rcv_lit;
    xfer_s    = sch2uca_valid & uca_ready;
    xlit_s    = sch2uca_lit;
    for (int i = 0; i < NE; i++) begin
      if (pop_s[i]) begin
        col_q.push_back(eng_lit[i]);
        if (eng_cnt[i] > 0) eng_cnt[i]--;
      end
    end
    @(posedge clk);
    #1;
    if (rd_s && arb_q.size() != 0) tmp_lit = arb_q.pop_front();
  endtask

  task automatic start_round();
    start = 1'b1;
    env_step();
    start = 1'b0;
  endtask

  task automatic finish_round();
    bit seen = 1'b0;
    eng_idle = 4'b1111;
    for (int c = 0; c < 12 && !seen; c++) begin
      env_step();
      if (round_done === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL finish_round round_done got 0 required 1 within 12 cycles");
    end
    env_step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    env_step();
    env_step();
    checks++;
    if ({pop_s, rd_s, push_s} !== 9'h000) begin
      errors++;
      $display("FAIL reset_comb got pop=%b rd=%b push=%b required 0", pop_s, rd_s, push_s);
    end
    checks++;
    if ({sch2uca_valid, sch2uca_lit, round_done, conflict_out, overflow, uc_count, eng_rcv_lit} !== 26'h0) begin
      errors++;
      $display("FAIL reset_regs got v=%b lit=%h done=%b cf=%b ov=%b cnt=%0d rcv=%h required 0",
               sch2uca_valid, sch2uca_lit, round_done, conflict_out, overflow, uc_count, eng_rcv_lit);
    end
    rst = 1'b1;
    env_step();
  endtask

  task automatic test_backpressure();
    eng_idle  = 4'b0000;
    uca_ready = 1'b0;
    start_round();
    eng_lit[3] = 10'h005;
    eng_cnt[3] = 2;
    env_step();
    checks++;
    if (pop_s !== 4'b1000) begin
      errors++;
      $display("FAIL bp_first_pop got %b required 1000", pop_s);
    end
    for (int s = 0; s < 3; s++) begin
      env_step();
      checks++;
      if (pop_s !== 4'b0000 || sch2uca_valid !== 1'b1 || sch2uca_lit !== 10'h005) begin
        errors++;
        $display("FAIL bp_stall%0d got pop=%b v=%b lit=%h required 0000 1 005", s, pop_s, sch2uca_valid, sch2uca_lit);
      end
    end
    uca_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      env_step();
      checks++;
      exp_lit = (col_q.size() != 0) ? col_q.pop_front() : 10'h3FF;
      if (xfer_s !== 1'b1 || xlit_s !== exp_lit) begin
        errors++;
        $display("FAIL bp_xfer%0d got xfer=%b lit=%h required 1 %h", s, xfer_s, xlit_s, exp_lit);
      end
      checks++;
      if (uc_count !== CW'(s + 1)) begin
        errors++;
        $display("FAIL bp_count%0d got %0d required %0d", s, uc_count, s + 1);
      end
    end
    finish_round();
  endtask

  task automatic test_rr();
    eng_idle = 4'b0000;
    uca_ready = 1'b1;
    start_round();
    checks++;
    if (uc_count !== 3'd0) begin
      errors++;
      $display("FAIL rr_count_clear got %0d required 0", uc_count);
    end
    eng_lit = '{10'h101, 10'h102, 10'h103, 10'h104};
    eng_cnt = '{100, 100, 0, 100};
    for (int s = 0; s < 5; s++) begin
      if (s == 4) eng_cnt = '{0, 0, 0, 0};
      env_step();
      if (s < 4) begin
        checks++;
        if (pop_s !== RR_POP[s]) begin
          errors++;
          $display("FAIL rr_pop%0d got %b required %b", s, pop_s, RR_POP[s]);
        end
      end
      if (s > 0) begin
        checks++;
        exp_lit = (col_q.size() != 0) ? col_q.pop_front() : 10'h3FF;
        if (xfer_s !== 1'b1 || xlit_s !== exp_lit) begin
          errors++;
          $display("FAIL rr_lit%0d got xfer=%b lit=%h required 1 %h", s, xfer_s, xlit_s, exp_lit);
        end
      end
    end
    checks++;
    if (uc_count !== 3'd4 || col_q.size() != 0) begin
      errors++;
      $display("FAIL rr_total got cnt=%0d left=%0d required 4 0", uc_count, col_q.size());
    end
    finish_round();
  endtask

  task automatic test_broadcast();
    eng_idle = 4'b0000;
    start_round();
    arb_q.push_back(10'h003); bc_exp.push_back(10'h003);
    arb_q.push_back(10'h3FD); bc_exp.push_back(10'h3FD);
    for (int s = 0; s < 6; s++) begin
      eng_rcv_full = BC_FULL[s];
      env_step();
      checks++;
      if (push_s !== BC_PUSH[s] || rd_s !== BC_RD[s]) begin
        errors++;
        $display("FAIL bc_step%0d got push=%b rd=%b required %b %b", s, push_s, rd_s, BC_PUSH[s], BC_RD[s]);
      end
      for (int i = 0; i < NE; i++) begin
        if (push_s[i]) begin
          checks++;
          exp_lit = (bc_idx[i] < bc_exp.size()) ? bc_exp[bc_idx[i]] : 10'h3FF;
          bc_idx[i]++;
          if (rcv_lit_s !== exp_lit) begin
            errors++;
            $display("FAIL bc_lit eng%0d got %h required %h", i, rcv_lit_s, exp_lit);
          end
        end
      end
    end
    checks++;
    if (bc_idx[0] != 2 || bc_idx[1] != 2 || bc_idx[2] != 2 || bc_idx[3] != 2) begin
      errors++;
      $display("FAIL bc_count got %0d %0d %0d %0d required 2 each", bc_idx[0], bc_idx[1], bc_idx[2], bc_idx[3]);
    end
    eng_rcv_full = 4'b0000;
    finish_round();
  endtask

  task automatic test_overflow();
    int n_xfer = 0;
    eng_idle = 4'b0000;
    uca_ready = 1'b1;
    start_round();
    eng_cnt = '{2, 2, 1, 1};
    for (int s = 0; s < 10; s++) begin
      env_step();
      if (xfer_s) begin
        n_xfer++;
        checks++;
        exp_lit = (col_q.size() != 0) ? col_q.pop_front() : 10'h3FF;
        if (xlit_s !== exp_lit) begin
          errors++;
          $display("FAIL ov_lit got %h required %h", xlit_s, exp_lit);
        end
      end
    end
    checks++;
    if (n_xfer != 4 || overflow !== 1'b1 || uc_count !== 3'd4 ||
        (eng_cnt[0] + eng_cnt[1] + eng_cnt[2] + eng_cnt[3]) != 2) begin
      errors++;
      $display("FAIL overflow got xfers=%0d ov=%b cnt=%0d left=%0d required 4 1 4 2", n_xfer, overflow, uc_count,
               eng_cnt[0] + eng_cnt[1] + eng_cnt[2] + eng_cnt[3]);
    end
  endtask

  task automatic test_conflict();
    arb_q.push_back(10'h011);
    env_step();
    checks++;
    if (rd_s !== 1'b1) begin
      errors++;
      $display("FAIL cf_rd got %b required 1", rd_s);
    end
    eng_rcv_full = 4'b1111;
    uca_conflict = 1'b1;
    arb_q.push_back(10'h022);
    env_step();
    uca_conflict = 1'b0;
    eng_rcv_full = 4'b0000;
    checks++;
    if (conflict_out !== 1'b1) begin
      errors++;
      $display("FAIL cf_out got %b required 1", conflict_out);
    end
    env_step();
    checks++;
    if (push_s !== 4'b0000 || pop_s !== 4'b0000 || rd_s !== 1'b0 || conflict_out !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL cf_halt got push=%b pop=%b rd=%b cf=%b ov=%b required 0000 0000 0 1 1",
               push_s, pop_s, rd_s, conflict_out, overflow);
    end
    start_round();
    env_step();
    checks++;
    if (conflict_out !== 1'b0 || pop_s !== 4'b0000) begin
      errors++;
      $display("FAIL cf_leave got cf=%b pop=%b required 0 0000", conflict_out, pop_s);
    end
    arb_q.delete();
    col_q.delete();
    eng_cnt = '{0, 0, 0, 0};
  endtask

  task automatic test_clean_round();
    int pulses = 0;
    eng_idle = 4'b1111;
    start_round();
    for (int s = 0; s < 8; s++) begin
      env_step();
      if (round_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || uc_count !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL clean_round got pulses=%0d cnt=%0d ov=%b required 1 0 0", pulses, uc_count, overflow);
    end
    eng_idle = 4'b0000;
    start_round();
    eng_cnt[1] = 5;
    arb_q.push_back(10'h044);
    env_step();
    rst = 1'b0;
    env_step();
    checks++;
    if ({sch2uca_valid, sch2uca_lit, round_done, conflict_out, overflow, uc_count, eng_rcv_lit} !== 26'h0) begin
      errors++;
      $display("FAIL mid_reset_regs got v=%b lit=%h cnt=%0d rcv=%h required 0", sch2uca_valid, sch2uca_lit, uc_count, eng_rcv_lit);
    end
    arb_q.push_back(10'h055);
    env_step();
    checks++;
    if (pop_s !== 4'b0000 || rd_s !== 1'b0 || push_s !== 4'b0000) begin
      errors++;
      $display("FAIL mid_reset_comb got pop=%b rd=%b push=%b required 0", pop_s, rd_s, push_s);
    end
    rst = 1'b1;
    env_step();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; uca_ready = 1'b0; uca_conflict = 1'b0;
    eng_idle = 4'b0000; eng_rcv_full = 4'b0000;
    eng_uc_valid = 4'b0000; eng_uc_lit = '0; uca2sch_valid = 1'b0; uca2sch_lit = 10'h000;
    eng_lit = '{10'h101, 10'h102, 10'h103, 10'h104};
    eng_cnt = '{0, 0, 0, 0};
    bc_idx  = '{0, 0, 0, 0};
    test_reset();
    test_backpressure();
    test_rr();
    test_broadcast();
    test_overflow();
    test_conflict();
    test_clean_round();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
